// File: rtl/mips_pkg.sv
// Shared opcodes, ALU operations and memory geometry for the single-cycle MIPS core.
// Defining MIPS_EXT_ISA_EN enables the extended instruction decode in mips.
package mips_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
  localparam logic [31:0] DATA_BASE = 32'h0000_0000;
  localparam int          MEM_DEPTH = 1024;
  localparam int          MEM_AW    = 10;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
    OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI = 6'h0e, OP_LUI  = 6'h0f,
    OP_LW    = 6'h23, OP_SW    = 6'h2b
  } opcode_e;

  typedef enum logic [5:0] {
    F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08,
    F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
    F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27,
    F_SLT  = 6'h2a, F_SLTU = 6'h2b
  } funct_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: arithmetic, logic, compares, shifts and upper-immediate load.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_e     alu_op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $signed(b) >>> shamt;
      ALU_LUI:  result = {b[15:0], 16'h0000};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mips_mem.sv
// Storage blocks of the core: instruction ROM, register file and data memory.
module mips_im
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] instr
);

  logic [31:0]       instruction_memory [0:MEM_DEPTH-1];
  logic [MEM_AW-1:0] word_idx;

  // Contents are preloaded by the simulation environment; the core only reads.
  assign word_idx = MEM_AW'((pc - TEXT_BASE) >> 2);
  assign instr    = instruction_memory[word_idx];

endmodule

module mips_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] rf [0:31];

  // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && wa != 5'd0) begin
      rf[wa] <= wd;
    end
  end

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

endmodule

module mips_dm
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [MEM_AW-1:0] idx,
  input  logic [31:0]       wd,
  output logic [31:0]       rd
);

  logic [31:0] dataMem [0:MEM_DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) dataMem[i] <= '0;
    end else if (we) begin
      dataMem[idx] <= wd;
    end
  end

  assign rd = dataMem[idx];

endmodule

// File: rtl/mips.sv
// Single-cycle MIPS core top: fetch, decode, execute, memory and writeback in one clock.
// Define MIPS_EXT_ISA_EN to decode the extended ISA; otherwise those encodings are nops.
module mips
  import mips_pkg::*;
(
  input  logic clk,
  input  logic rst
);

  logic [31:0] PC;
  logic [31:0] AnInstruction;

  opcode_e     op;
  funct_e      fn;
  logic [4:0]  rs, rt, rd, shamt;
  logic [25:0] instr_index;
  logic [31:0] pc_plus4, sext_imm, zext_imm, branch_target, jump_target;
  logic [31:0] rd1, rd2, alu_b, alu_result, dm_rd, wd, imm, next_pc;
  logic [MEM_AW-1:0] dm_idx;
  logic        reg_we, use_imm, mem_we, mem_to_reg, link;
  logic [4:0]  wa;
  alu_op_e     alu_op;

  assign op          = opcode_e'(AnInstruction[31:26]);
  assign fn          = funct_e'(AnInstruction[5:0]);
  assign rs          = AnInstruction[25:21];
  assign rt          = AnInstruction[20:16];
  assign rd          = AnInstruction[15:11];
  assign shamt       = AnInstruction[10:6];
  assign instr_index = AnInstruction[25:0];

  assign pc_plus4      = PC + 32'd4;
  assign sext_imm      = {{16{AnInstruction[15]}}, AnInstruction[15:0]};
  assign zext_imm      = {16'h0000, AnInstruction[15:0]};
  assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    reg_we     = 1'b0;
    wa         = rt;
    use_imm    = 1'b0;
    imm        = sext_imm;
    alu_op     = ALU_ADD;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    link       = 1'b0;
    next_pc    = pc_plus4;
    case (op)
      OP_RTYPE: begin
        wa = rd;
        case (fn)
          F_ADDU: begin reg_we = 1'b1; alu_op = ALU_ADD; end
          F_SUBU: begin reg_we = 1'b1; alu_op = ALU_SUB; end
`ifdef MIPS_EXT_ISA_EN
          F_ADD:  begin reg_we = 1'b1; alu_op = ALU_ADD;  end
          F_SUB:  begin reg_we = 1'b1; alu_op = ALU_SUB;  end
          F_AND:  begin reg_we = 1'b1; alu_op = ALU_AND;  end
          F_OR:   begin reg_we = 1'b1; alu_op = ALU_OR;   end
          F_XOR:  begin reg_we = 1'b1; alu_op = ALU_XOR;  end
          F_NOR:  begin reg_we = 1'b1; alu_op = ALU_NOR;  end
          F_SLT:  begin reg_we = 1'b1; alu_op = ALU_SLT;  end
          F_SLTU: begin reg_we = 1'b1; alu_op = ALU_SLTU; end
          F_SLL:  begin reg_we = 1'b1; alu_op = ALU_SLL;  end
          F_SRL:  begin reg_we = 1'b1; alu_op = ALU_SRL;  end
          F_SRA:  begin reg_we = 1'b1; alu_op = ALU_SRA;  end
          F_JR:   next_pc = rd1;
`endif
          default: ;
        endcase
      end
      OP_ORI: begin reg_we = 1'b1; use_imm = 1'b1; imm = zext_imm; alu_op = ALU_OR; end
      OP_LUI: begin reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_LUI; end
      OP_LW:  begin reg_we = 1'b1; use_imm = 1'b1; mem_to_reg = 1'b1; end
      OP_SW:  begin use_imm = 1'b1; mem_we = 1'b1; end
      OP_BEQ: if (rd1 == rd2) next_pc = branch_target;
      OP_J:   next_pc = jump_target;
`ifdef MIPS_EXT_ISA_EN
      OP_ADDI, OP_ADDIU: begin reg_we = 1'b1; use_imm = 1'b1; end
      OP_SLTI: begin reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT; end
      OP_ANDI: begin reg_we = 1'b1; use_imm = 1'b1; imm = zext_imm; alu_op = ALU_AND; end
      OP_XORI: begin reg_we = 1'b1; use_imm = 1'b1; imm = zext_imm; alu_op = ALU_XOR; end
      OP_BNE:  if (rd1 != rd2) next_pc = branch_target;
      OP_JAL:  begin reg_we = 1'b1; wa = 5'd31; link = 1'b1; next_pc = jump_target; end
`endif
      default: ;
    endcase
  end

  assign alu_b  = use_imm ? imm : rd2;
  assign dm_idx = MEM_AW'((alu_result - DATA_BASE) >> 2);
  assign wd     = link ? pc_plus4 : (mem_to_reg ? dm_rd : alu_result);

  // NOTE: state registers use non-blocking assignment so all edge updates commit together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) PC <= TEXT_BASE;
    else     PC <= next_pc;
  end

  mips_im im (
    .pc    (PC),
    .instr (AnInstruction)
  );

  mips_rf rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .we  (reg_we),
    .wa  (wa),
    .wd  (wd),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  mips_alu alu (
    .a      (rd1),
    .b      (alu_b),
    .shamt  (shamt),
    .alu_op (alu_op),
    .result (alu_result)
  );

  mips_dm dm (
    .clk (clk),
    .rst (rst),
    .we  (mem_we),
    .idx (dm_idx),
    .wd  (rd2),
    .rd  (dm_rd)
  );

endmodule

// File: tb/tb_mips.sv
// Self-checking bench for mips: a directed program table plus random programs
// compared cycle by cycle against an instruction-level reference interpreter.
module tb_mips;

`ifdef MIPS_EXT_ISA_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] prog [1024];
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [1024];
  logic [31:0] m_pc;

  typedef struct {
    string       name;
    logic [31:0] ins;
    bit          exec;
    bit          is_mem;
    int          idx;
    logic [31:0] val;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [$];

  mips dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_im();
    for (int i = 0; i < 1024; i++) dut.im.instruction_memory[i] = prog[i];
  endtask

  // Reference interpreter: executes one instruction straight from the ISA rules.
  task automatic model_step();
    logic [31:0] ins, a, b, simm, zimm, res, npc, addr;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, wr;
    bit          we;
    int          idx;
    idx  = int'((m_pc - 32'h3000) >> 2) & 1023;
    ins  = prog[idx];
    op   = ins[31:26];
    fn   = ins[5:0];
    rs   = ins[25:21];
    rt   = ins[20:16];
    rd   = ins[15:11];
    sh   = ins[10:6];
    a    = m_rf[rs];
    b    = m_rf[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    npc  = m_pc + 4;
    addr = a + simm;
    we   = 1'b0;
    wr   = rt;
    res  = '0;
    case (op)
      6'h00: begin
        wr = rd;
        case (fn)
          6'h21: begin we = 1; res = a + b; end
          6'h23: begin we = 1; res = a - b; end
          default: if (EXT) begin
            we = 1;
            case (fn)
              6'h20: res = a + b;
              6'h22: res = a - b;
              6'h24: res = a & b;
              6'h25: res = a | b;
              6'h26: res = a ^ b;
              6'h27: res = ~(a | b);
              6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
              6'h2b: res = (a < b) ? 32'd1 : 32'd0;
              6'h00: res = b << sh;
              6'h02: res = b >> sh;
              6'h03: res = $signed(b) >>> sh;
              6'h08: begin we = 0; npc = a; end
              default: we = 0;
            endcase
          end
        endcase
      end
      6'h0d: begin we = 1; res = a | zimm; end
      6'h0f: begin we = 1; res = {ins[15:0], 16'h0}; end
      6'h23: begin we = 1; res = m_dm[int'(addr[11:2])]; end
      6'h2b: m_dm[int'(addr[11:2])] = b;
      6'h04: if (a == b) npc = m_pc + 4 + (simm << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      default: if (EXT) begin
        case (op)
          6'h08, 6'h09: begin we = 1; res = a + simm; end
          6'h0a: begin we = 1; res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; end
          6'h0c: begin we = 1; res = a & zimm; end
          6'h0e: begin we = 1; res = a ^ zimm; end
          6'h05: if (a != b) npc = m_pc + 4 + (simm << 2);
          6'h03: begin we = 1; wr = 5'd31; res = m_pc + 4; npc = {npc[31:28], ins[25:0], 2'b00}; end
          default: ;
        endcase
      end
    endcase
    if (we && wr != 5'd0) m_rf[wr] = res;
    m_pc = npc;
  endtask

  function automatic logic [31:0] rand_instr(int pos);
    logic [5:0] functs [14] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                                6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h3f};
    logic [5:0] iops [8] = '{6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h0b};
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    sh  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: return {6'h00, rs, rt, rd, sh, functs[$urandom_range(0, 13)]};
      3, 4:    return {iops[$urandom_range(0, 7)], rs, rt, imm};
      5:       return {6'h23, rs, rt, imm};
      6:       return {6'h2b, rs, rt, imm};
      7:       return {($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt, 16'($urandom_range(0, 3))};
      8:       return {($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03,
                       26'(32'h0C00 + pos + $urandom_range(1, 4))};
      default: return $urandom;
    endcase
  endfunction

  task automatic add_vec(input string n, input logic [31:0] ins, input bit ex, input bit mem,
                         input int idx, input logic [31:0] val, input logic [31:0] pc);
    vecs.push_back('{n, ins, ex, mem, idx, val, pc});
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;

    add_vec("ori",       32'h34011234, 1, 0, 1,  32'h00001234, 32'h3004);
    add_vec("lui",       32'h3C02FFFF, 1, 0, 2,  32'hFFFF0000, 32'h3008);
    add_vec("ori_low",   32'h3442FFFF, 1, 0, 2,  32'hFFFFFFFF, 32'h300C);
    add_vec("addi",      32'h2003FFFF, 1, 0, 3,  EXT ? 32'hFFFFFFFF : 32'h0, 32'h3010);
    add_vec("sw",        32'hAC010008, 1, 1, 2,  32'h00001234, 32'h3014);
    add_vec("lw",        32'h8C040008, 1, 0, 4,  32'h00001234, 32'h3018);
    add_vec("slt",       32'h0041282A, 1, 0, 5,  EXT ? 32'h1 : 32'h0, 32'h301C);
    add_vec("sltu",      32'h0041302B, 1, 0, 6,  32'h0, 32'h3020);
    add_vec("sra",       32'h00023903, 1, 0, 7,  EXT ? 32'hFFFFFFFF : 32'h0, 32'h3024);
    add_vec("srl",       32'h00024102, 1, 0, 8,  EXT ? 32'h0FFFFFFF : 32'h0, 32'h3028);
    add_vec("write_r0",  32'h00210021, 1, 0, 0,  32'h0, 32'h302C);
    add_vec("beq_taken", 32'h10240001, 1, 0, 1,  32'h00001234, 32'h3034);
    add_vec("skipped",   32'h3409DEAD, 0, 0, 9,  32'h0, 32'h0);
    add_vec("bne_fall",  32'h14240001, 1, 0, 1,  32'h00001234, 32'h3038);
    add_vec("ori_r9",    32'h34090077, 1, 0, 9,  32'h00000077, 32'h303C);
    add_vec("addu",      32'h00225021, 1, 0, 10, 32'h00001233, 32'h3040);
    add_vec("jal",       32'h0C000C20, 1, 0, 31, EXT ? 32'h3044 : 32'h0, EXT ? 32'h3080 : 32'h3044);

    for (int i = 0; i < 1024; i++) prog[i] = '0;
    foreach (vecs[i]) prog[i] = vecs[i].ins;
    prog[17] = 32'h08000C11;  // j 0x3044
    prog[32] = 32'h03E00008;  // jr $31
    load_im();
    #1;
    check("reset_pc", dut.PC, 32'h3000);
    for (int i = 1; i < 32; i++) check($sformatf("reset_rf%0d", i), dut.rf.rf[i], 32'h0);
    for (int i = 0; i <= 8; i++) check($sformatf("reset_dm%0d", i), dut.dm.dataMem[i], 32'h0);

    @(negedge clk) rst = 1'b0;
    foreach (vecs[i]) begin
      if (vecs[i].exec) begin
        step();
        check({vecs[i].name, "_pc"}, dut.PC, vecs[i].pc);
        if (vecs[i].is_mem) check(vecs[i].name, dut.dm.dataMem[vecs[i].idx], vecs[i].val);
        else                check(vecs[i].name, dut.rf.rf[vecs[i].idx], vecs[i].val);
      end
    end
    step();
    check("jr_return_pc", dut.PC, 32'h3044);
    check("link_r31", dut.rf.rf[31], EXT ? 32'h3044 : 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("j_hold_pc", dut.PC, 32'h3044);
    end

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_pc", dut.PC, 32'h3000);
    check("midreset_rf1", dut.rf.rf[1], 32'h0);
    check("midreset_rf9", dut.rf.rf[9], 32'h0);
    check("midreset_dm2", dut.dm.dataMem[2], 32'h0);

    for (int run = 0; run < 4; run++) begin
      for (int i = 0; i < 1024; i++) prog[i] = (i < 60) ? rand_instr(i) : 32'h0;
      load_im();
      m_pc = 32'h3000;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      for (int i = 0; i < 1024; i++) m_dm[i] = '0;
      @(negedge clk) rst = 1'b0;
      for (int c = 0; c < 90; c++) begin
        step();
        model_step();
        check($sformatf("rand%0d_pc_c%0d", run, c), dut.PC, m_pc);
      end
      for (int i = 0; i < 32; i++) check($sformatf("rand%0d_rf%0d", run, i), dut.rf.rf[i], m_rf[i]);
      for (int i = 0; i < 1024; i++) begin
        if (m_dm[i] != 32'h0 || dut.dm.dataMem[i] != 32'h0)
          check($sformatf("rand%0d_dm%0d", run, i), dut.dm.dataMem[i], m_dm[i]);
      end
      @(negedge clk) rst = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips.md
# mips

Single-cycle 32-bit MIPS processor core, the top of the CPU design, containing instruction memory, register file, data memory, ALU and control. Every instruction completes in one clock cycle. Programs are preloaded into instruction memory as hex words. Architectural state (PC, registers, data memory) is inspected hierarchically by simulation benches.

## Interface
- Parameters: none. Text base 0x0000_3000 and data base 0x0000_0000 are fixed constants.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Required hierarchical names:
  - PC: 32-bit program counter.
  - AnInstruction: 32-bit current instruction.
  - im.instruction_memory: 1024×32 ROM array, loaded by $readmemh.
  - rf.rf[0:31]: 32×32 registers.
  - dm.dataMem: 1024×32 word array.

## Operation
- Fetch: AnInstruction = im.instruction_memory[(PC-0x3000)>>2][9:0].
- Base ISA: addu, subu, ori, lw, sw, beq, lui, j.
- Extended ISA:
  - R-type: add, sub, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi, addiu, andi, xori, slti, bne.
  - J-type: jal.
- Immediates:
  - addi, addiu, slti, lw, sw: sign-extended.
  - andi, ori, xori: zero-extended.
  - lui: imm<<16.
- add/addi behave as addu/addiu: 32-bit wrap, no overflow exception.
- slt/slti compare signed; sltu compares unsigned; result is 0 or 1.
- Shifts use shamt[10:6]; sra is arithmetic.
- Branch target = PC+4+(sext(imm)<<2). There is no delay slot.
- j/jal target = {PC+4[31:28], instr_index, 2'b00}.
- jal writes PC+4 to r31. jr sets PC = rs.
- Sequential next PC = PC+4.
- lw/sw address = rs+sext(imm), word aligned. Memory index is addr[11:2]; low two bits are ignored.
- r0 is always zero. Writes to r0 are discarded.
- Unknown opcode/funct executes as nop: PC+4, no writes.

## Timing
- Single cycle: register-file reads, ALU, DM read and next-PC logic are combinational within the cycle.
- PC, register-file write and DM write commit on the same rising clk edge.
- Reset (asynchronous, any time including mid-program):
  - PC = 0x0000_3000.
  - All rf.rf entries = 0.
  - All dm.dataMem entries = 0.
  - Instruction memory is untouched.
- First rising edge after rst deasserts executes the instruction at 0x3000.
- lw then a dependent instruction in the next cycle sees the loaded value; there are no hazards.
- sw and lw to the same address in consecutive instructions: lw returns the stored word.

## Configuration
- MIPS_EXT_ISA_EN: defined → extended ISA decoded as above.
- Not defined → only the base ISA is decoded; extended encodings execute as nop (PC+4, no state change).

## Structure
- Package mips_pkg holds:
  - opcode and funct constants;
  - ALU-op enum;
  - TEXT_BASE = 32'h3000 and DATA_BASE = 32'h0;
  - memory depth 1024.
- Instances im, rf, dm are required with the names above.
- The one natural sub-module is mips_alu: combinational, inputs a, b, shamt, alu_op; output result.

## Test plan
- Reset: assert rst → PC=0x3000; rf[1..31]=0; dataMem[0..8]=0.
- Immediates:
  - ori $1,$0,0x1234 → rf[1]=0x00001234.
  - lui $2,0xFFFF; ori $2,$2,0xFFFF → rf[2]=0xFFFFFFFF.
  - addi $3,$0,-1 → rf[3]=0xFFFFFFFF.
- Memory: sw $1,8($0) → dataMem[2]=0x00001234; then lw $4,8($0) → rf[4]=0x00001234.
- Compares:
  - slt $5,$2,$1 → 1; sltu $6,$2,$1 → 0.
  - sra $7,$2,4 → 0xFFFFFFFF; srl $8,$2,4 → 0x0FFFFFFF.
- Control flow:
  - beq taken skips the next instruction; bne not-taken falls through.
  - jal at 0x3040 → rf[31]=0x3044; jr $31 returns to 0x3044.
  - j loops in place, holding PC steady.
- Writes to $0 leave rf[0]=0. Build without MIPS_EXT_ISA_EN: slt leaves rd unchanged and PC advances by 4.
